sipo_collector: RTL and testbench
=================================

Name: sipo_collector

Overview:
- Serial-in parallel-out collector; the receive-side counterpart of the team's parallel-in serial-out shifter.
- Accepts one BIT-wide word per valid/ready transfer and assembles NDATA words into a parallel frame.
- Presents the frame with a valid flag and holds it until the consumer acknowledges.
- Element 0 holds the first word received, matching the shifter, which emits element 0 first.

Parameters:
- BIT, 8, width of one word.
- NDATA, 3, words per frame; must be >= 2.
- CW (localparam), max(1,$clog2(NDATA)), width of the word counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  sender has a word on i_data.
- i_data  input  BIT  serial word.
- o_ready  output  1  collector accepts a word this cycle.
- i_clear  input  1  synchronous flush of any partial or complete frame.
- o_data  output  BIT x [0:NDATA-1] (unpacked)  assembled frame.
- o_valid  output  1  frame complete and stable.
- i_ready  input  1  consumer takes the frame this cycle.
- o_count  output  CW  words captured in the current partial frame.

Behaviour:
- Reset (i_rst_n low, asynchronous): state FILL, count 0, all o_data elements 0, o_valid 0.
- Reset deassertion is synchronised by the integrator, not inside this block.
- A transfer happens only when i_valid && o_ready at a rising edge.
- When o_ready is 0, i_valid is ignored; the sender must hold its word.
- States:
  - FILL: o_ready=1, o_valid=0.
    - On transfer: data[count] <= i_data.
    - If count==NDATA-1: count <= 0 and go to FULL; otherwise count <= count+1.
  - FULL: o_valid=1, o_ready=0 (base build); o_data is frozen.
    - On i_ready: go to FILL next cycle.
    - If i_ready stays low, hold indefinitely.
- Latency:
  - o_valid rises the cycle after the NDATA-th transfer.
  - Minimum frame period in the base build is NDATA+1 cycles (one bubble for the handshake).
- i_clear has the highest priority below reset: count <= 0, state <= FILL, o_valid drops next cycle.
  - Buffer contents are not zeroed.
  - A transfer coinciding with i_clear is discarded.
- i_clear together with i_ready in FULL: acts as clear; the frame counts as consumed.
- o_count is 0 throughout FULL and wraps from NDATA-1 to 0 on frame completion; no other wrap exists.
- Words already captured are never overwritten while o_valid=1.

Optional Feature:
- Macro SIPO_OVERLAP_EN.
- When defined, in FULL: o_ready = i_ready (combinational path from i_ready to o_ready).
  - A transfer in the same cycle as i_ready writes data[0] and sets count=1 (or goes straight back to FULL when NDATA==1, which is disallowed).
  - State goes to FILL.
  - Sustained throughput is one frame per NDATA cycles with no bubble.
- When undefined: o_ready=0 in FULL, with the one-bubble behaviour above.
- The interface is identical in both builds.

Decomposition:
- Package sipo_pkg: state enum typedef (FILL, FULL) and a function computing CW from NDATA.
- No sub-module; a single FSM plus register array is natural.
- The frame register array is written by index and needs no shift chain.

Test Plan (BIT=8, NDATA=3):
- Reset mid-frame: send 0x11 and 0x22, assert i_rst_n low asynchronously between edges.
  - Required: o_valid=0, o_count=0 and o_data={0,0,0} immediately.
  - A subsequent 3-word frame starts at element 0.
- Basic frame: send 0xA1, 0xB2, 0xC3 back-to-back with i_ready=0.
  - Required: o_valid rises the cycle after 0xC3, o_data={A1,B2,C3}, o_ready=0.
  - Frame held for 10 cycles; i_ready pulse returns to FILL next cycle.
- Sender gaps: i_valid toggles 1,0,0,1,0,1 with 0x01, 0x02, 0x03.
  - Required: o_count steps 1,1,1,2,2 then FULL with {01,02,03}.
- Backpressure: in FULL, drive i_valid=1 with 0xEE for 5 cycles.
  - Required: o_ready=0 and no element changes.
  - After i_ready, 0xEE is captured into element 0 (base build, one cycle later).
- Clear: after 2 words, assert i_clear with i_valid=1 and 0x55.
  - Required: o_count=0 and 0x55 dropped; the next 3 words form a clean frame.
- Overlap (SIPO_OVERLAP_EN): a continuous 9-word stream 0x01..0x09 with i_ready=1.
  - Required: three frames {01,02,03}, {04,05,06}, {07,08,09}, each o_valid one cycle wide, no stall cycles.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out collector.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sipo_pkg;

   // FILL gathers words; FULL presents a finished frame until it is taken.
   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   // Word-counter width: enough to index NDATA words, never narrower than 1 bit.
   function automatic int calc_cw(input int ndata);
      int w;
      w = $clog2(ndata);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sipo_collector.sv
// Collects NDATA serial BIT-wide words into a parallel frame (element 0 = first word).
// Latency: o_valid rises the cycle after the NDATA-th transfer; frame held until i_ready.
// Backpressure: o_ready=0 while a frame is held; with SIPO_OVERLAP_EN, o_ready follows i_ready in FULL.
module sipo_collector
   import sipo_pkg::*;
#(
   parameter  int BIT   = 8,
   parameter  int NDATA = 3,
   localparam int CW    = calc_cw(NDATA)
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_valid,
   input  logic [BIT-1:0] i_data,
   output logic           o_ready,
   input  logic           i_clear,
   output logic [BIT-1:0] o_data [0:NDATA-1],
   output logic           o_valid,
   input  logic           i_ready,
   output logic [CW-1:0]  o_count
);

   localparam logic [CW-1:0] LAST = CW'(NDATA - 1);

   state_t         state;
   state_t         state_nxt;
   logic [CW-1:0]  count;
   logic [CW-1:0]  count_nxt;
   logic [BIT-1:0] data [0:NDATA-1];
   logic           xfer;
   logic           wr_en;
   logic [CW-1:0]  wr_idx;

   // Ready is only withheld while a completed frame waits for its consumer.
   always_comb begin
      o_ready = 1'b1;
      if (state == FULL) begin
`ifdef SIPO_OVERLAP_EN
         o_ready = i_ready;
`else
         o_ready = 1'b0;
`endif
      end
   end

   assign xfer = i_valid & o_ready;

   // Next state, counter and write strobe; clear overrides any transfer.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      wr_en     = 1'b0;
      wr_idx    = count;
      if (i_clear) begin
         state_nxt = FILL;
         count_nxt = '0;
      end else begin
         case (state)
            FILL: begin
               if (xfer) begin
                  wr_en  = 1'b1;
                  wr_idx = count;
                  if (count == LAST) begin
                     count_nxt = '0;
                     state_nxt = FULL;
                  end else begin
                     count_nxt = count + CW'(1);
                  end
               end
            end
            FULL: begin
               if (i_ready) begin
                  state_nxt = FILL;
`ifdef SIPO_OVERLAP_EN
                  // The first word of the next frame lands while the old one is taken.
                  if (xfer) begin
                     wr_en     = 1'b1;
                     wr_idx    = '0;
                     count_nxt = CW'(1);
                  end
`endif
               end
            end
            default: begin
               state_nxt = FILL;
               count_nxt = '0;
            end
         endcase
      end
   end

   // State and word counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= FILL;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // Frame buffer written by index; untouched while a frame is presented.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NDATA; i++) begin
            data[i] <= '0;
         end
      end else if (wr_en) begin
         data[wr_idx] <= i_data;
      end
   end

   assign o_data  = data;
   assign o_valid = (state == FULL);
   assign o_count = count;

endmodule

// File: tb/tb_sipo_collector.sv
// Self-checking bench for sipo_collector (BIT=8, NDATA=3), directed plus random stimulus.
// Latency: one check set per cycle, sampled mid-cycle against a queue-based reference.
// Backpressure: the sender holds its word until the reference says it was accepted.
module tb_sipo_collector;

   localparam int BIT   = 8;
   localparam int NDATA = 3;
`ifdef SIPO_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic           i_clk = 1'b0;
   logic           i_rst_n;
   logic           i_valid;
   logic [BIT-1:0] i_data;
   logic           o_ready;
   logic           i_clear;
   logic [BIT-1:0] o_data [0:NDATA-1];
   logic           o_valid;
   logic           i_ready;
   logic [1:0]     o_count;

   int errors = 0;
   int checks = 0;

   // Reference: buffer image, words accepted into the current partial frame, frame-held flag.
   logic [BIT-1:0] m_buf [0:NDATA-1];
   logic [BIT-1:0] acc [$];
   bit             m_full;

   sipo_collector #(.BIT(BIT), .NDATA(NDATA)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .i_data  (i_data),
      .o_ready (o_ready),
      .i_clear (i_clear),
      .o_data  (o_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_count (o_count)
   );

   // 10 ns clock period.
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit m_ready();
      return !m_full || (OVL && (i_ready == 1'b1));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NDATA; i++) m_buf[i] = '0;
      acc.delete();
      m_full = 1'b0;
   endtask

   // Rising-edge update of the reference from the inputs currently applied.
   task automatic model_edge();
      bit x;
      x = i_valid && m_ready();
      if (i_clear) begin
         acc.delete();
         m_full = 1'b0;
      end else begin
         if (x) begin
            m_buf[acc.size()] = i_data;
            acc.push_back(i_data);
         end
         if (m_full && i_ready) begin
            m_full = 1'b0;
         end else if (acc.size() == NDATA) begin
            m_full = 1'b1;
            acc.delete();
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".ready"}, 32'(o_ready), 32'(m_ready()));
      check({tag, ".valid"}, 32'(o_valid), 32'(m_full));
      check({tag, ".count"}, 32'(o_count), m_full ? 32'd0 : 32'(acc.size()));
      check({tag, ".data"}, {8'h00, o_data[0], o_data[1], o_data[2]},
            {8'h00, m_buf[0], m_buf[1], m_buf[2]});
   endtask

   // One clock cycle: apply inputs (at edge+1), compare mid-cycle, advance the model at the edge.
   task automatic cycle(input bit v, input logic [BIT-1:0] d, input bit clr, input bit rdy,
                        input string tag, output bit accepted);
      i_valid = v;
      i_data  = d;
      i_clear = clr;
      i_ready = rdy;
      #4;
      check_outputs(tag);
      accepted = v && !clr && m_ready();
      @(posedge i_clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n, input bit rdy, input string tag);
      bit a;
      for (int i = 0; i < n; i++) cycle(1'b0, BIT'($urandom), 1'b0, rdy, tag, a);
   endtask

   // Sender holds the word until accepted; stalled cycles are tallied.
   task automatic send(input logic [BIT-1:0] d, input bit rdy, input string tag, inout int stalls);
      bit a;
      for (int t = 0; t < 20; t++) begin
         cycle(1'b1, d, 1'b0, rdy, tag, a);
         if (a) return;
         stalls++;
      end
      check({tag, ".send_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      int stalls;
      bit a;
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      i_clear = 1'b0;
      i_ready = 1'b0;
      model_reset();
      @(posedge i_clk);
      #1;
      check_outputs("reset");
      i_rst_n = 1'b1;

      // Reset mid-frame: asynchronous assertion between edges.
      stalls = 0;
      send(8'h11, 1'b0, "rst_pre", stalls);
      send(8'h22, 1'b0, "rst_pre", stalls);
      #2;
      i_rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("rst_async");
      check("rst_async.data_const", {8'h00, o_data[0], o_data[1], o_data[2]}, 32'h0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      send(8'h31, 1'b0, "rst_post", stalls);
      send(8'h32, 1'b0, "rst_post", stalls);
      send(8'h33, 1'b0, "rst_post", stalls);
      idle(1, 1'b0, "rst_post_full");
      check("rst_post.frame", {8'h00, o_data[0], o_data[1], o_data[2]}, 32'h00313233);
      idle(1, 1'b1, "rst_post_take");

      // Basic frame, held 10 cycles, then consumed.
      send(8'hA1, 1'b0, "basic", stalls);
      send(8'hB2, 1'b0, "basic", stalls);
      send(8'hC3, 1'b0, "basic", stalls);
      idle(10, 1'b0, "basic_hold");
      check("basic.frame", {8'h00, o_data[0], o_data[1], o_data[2]}, 32'h00A1B2C3);
      check("basic.valid", 32'(o_valid), 32'd1);
      idle(1, 1'b1, "basic_take");
      idle(1, 1'b0, "basic_fill");
      check("basic.back_to_fill", 32'(o_valid), 32'd0);

      // Sender gaps: valid pattern 1,0,0,1,0,1.
      cycle(1'b1, 8'h01, 1'b0, 1'b0, "gaps", a);
      cycle(1'b0, 8'h77, 1'b0, 1'b0, "gaps", a);
      cycle(1'b0, 8'h77, 1'b0, 1'b0, "gaps", a);
      cycle(1'b1, 8'h02, 1'b0, 1'b0, "gaps", a);
      cycle(1'b0, 8'h77, 1'b0, 1'b0, "gaps", a);
      cycle(1'b1, 8'h03, 1'b0, 1'b0, "gaps", a);
      #4;
      check("gaps.frame", {8'h00, o_data[0], o_data[1], o_data[2]}, 32'h00010203);
      @(posedge i_clk);
      model_edge();
      #1;

      // Backpressure: word held against a full collector, then released.
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0, "bp_hold", a);
      cycle(1'b1, 8'hEE, 1'b0, 1'b1, "bp_take", a);
      if (!a) cycle(1'b1, 8'hEE, 1'b0, 1'b0, "bp_late", a);
      #4;
      check("bp.elem0", 32'(o_data[0]), 32'h0000_00EE);
      check("bp.count", 32'(o_count), 32'd1);
      @(posedge i_clk);
      model_edge();
      #1;

      // Clear after two words with a coincident transfer.
      send(8'h44, 1'b0, "clr_pre", stalls);
      cycle(1'b1, 8'h55, 1'b1, 1'b0, "clr", a);
      #4;
      check("clr.count", 32'(o_count), 32'd0);
      @(posedge i_clk);
      model_edge();
      #1;
      send(8'h61, 1'b0, "clr_post", stalls);
      send(8'h62, 1'b0, "clr_post", stalls);
      send(8'h63, 1'b0, "clr_post", stalls);
      idle(1, 1'b0, "clr_full");
      check("clr.frame", {8'h00, o_data[0], o_data[1], o_data[2]}, 32'h00616263);
      idle(1, 1'b1, "clr_take");

      // Continuous nine-word stream with the consumer always ready.
      stalls = 0;
      for (int w = 1; w <= 9; w++) send(BIT'(w), 1'b1, "stream", stalls);
      check("stream.stalls", 32'(stalls), OVL ? 32'd0 : 32'd2);
      idle(2, 1'b1, "stream_drain");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0), BIT'($urandom), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 2) == 0), "rand", a);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
